lif_rate_decoder: RTL
=====================

# lif_rate_decoder

Spike-train readout block for the LIF neuron: samples the neuron's spike output, counts rising edges over a fixed window of 2^WIN_LOG2 cycles, and measures the inter-spike interval (ISI). It is the consumer of the neuron's spike stream, converting spikes back into a rate value. Each closed window produces one result, presented on a valid/ready output with overrun flagging.

## Interface
- WIN_LOG2, default 8: window length is 2^WIN_LOG2 cycles.
- ISI_W, default 10: ISI counter width; saturates at 2^ISI_W-1.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- ena  in  1  enable; low holds the block in IDLE.
- spike_in  in  1  neuron spike level (uo_out[7]); may be multi-cycle.
- out_ready  in  1  consumer ready.
- out_valid  out  1  result pending.
- rate_out  out  WIN_LOG2+1  rising-edge count of the last closed window.
- isi_out  out  ISI_W  last ISI completed inside that window; 0 if none.
- overrun  out  1  sticky; set when an unread result is overwritten.

## Operation
- Input path: spike_s <= spike_in; spike_d <= spike_s. These registers always run, including in IDLE. edge = spike_s & ~spike_d.
- A level held high for N cycles counts as one spike. Back-to-back edges need at least one low cycle, so the minimum ISI is 2.
- States: IDLE and COUNT.
  - IDLE -> COUNT on the first edge with ena=1. The window counter wcnt=0 and spike_cnt=0 on entry.
  - COUNT -> IDLE on any edge with ena=0. This clears wcnt, spike_cnt, isi_timer and have_prev. out_valid, rate_out, isi_out and overrun keep their values.
- In COUNT, each clock:
  - wcnt increments and wraps at 2^WIN_LOG2-1.
  - spike_cnt += edge.
- Window close, when wcnt = 2^WIN_LOG2-1:
  - rate_out <= spike_cnt + edge. An edge on the last cycle belongs to the closing window.
  - isi_out <= the window's ISI register, or the ISI captured this cycle.
  - out_valid <= 1; spike_cnt <= 0.
  - The next window starts with no gap.
- Width: spike_cnt is WIN_LOG2+1 bits. The maximum count is 2^(WIN_LOG2-1), so it never wraps.
- ISI measurement:
  - isi_timer is ISI_W bits and saturates at its maximum.
  - On an edge: if have_prev, capture isi_timer into the window ISI register. Then isi_timer <= 1 and have_prev <= 1.
  - Otherwise isi_timer increments when have_prev is set.
  - Edges at cycles t1 and t2 capture t2-t1, saturated.
  - isi_timer and have_prev persist across window boundaries. The window ISI register clears to 0 at each window start.
- Handshake:
  - out_valid & out_ready at a clock edge clears out_valid.
  - If a window close happens on the same edge, the close wins: the new result loads and out_valid stays 1, with no overrun.
  - If a window closes while out_valid=1 and out_ready=0, the result is overwritten and overrun <= 1.
- overrun clears only on rst.

## Timing
- Reset: state=IDLE. All counters, sync registers and outputs are 0: out_valid=0, rate_out=0, isi_out=0, overrun=0.
- Reset mid-window discards the partial window; no out_valid results.
- rst has priority over ena and out_ready.
- Spike latency: spike_in first sampled high at edge N is counted at edge N+1.
- A window spans 2^WIN_LOG2 consecutive COUNT cycles. out_valid rises at the edge that ends the window's last cycle.
- With ena held high, out_valid rises every 2^WIN_LOG2 cycles.
- Outputs are registered and have no combinational path from any input.
- out_ready may be held high permanently; out_valid is then a 1-cycle pulse per window.

## Test plan
Benches run with WIN_LOG2=4 (16-cycle windows) and ISI_W=6.
- Reset: assert rst for 2 cycles with spike_in toggling -> out_valid=0, rate_out=0, isi_out=0, overrun=0, and no out_valid for 16 cycles after rst without ena.
- Silent window: ena=1, spike_in=0, out_ready=1 -> out_valid pulses 16 cycles after COUNT entry with rate_out=0 and isi_out=0; repeats every 16 cycles.
- Periodic spikes: 1-cycle pulses every 4 cycles aligned to the window -> rate_out=4 and isi_out=4 in steady-state windows. Pulses every 50 cycles -> isi_out=50. Pulses every 70 cycles -> isi_out=63 (saturated).
- Held level: spike_in high for 10 cycles, then low -> rate_out=1 for that window.
- Overrun: out_ready=0 for two windows with 3 and then 5 spikes -> rate_out=5 and overrun=1. Then set out_ready=1 -> out_valid clears next edge and overrun stays 1.
- Simultaneous close and accept: out_ready=1 on the close edge with out_valid=1 -> new value loaded, out_valid remains 1, overrun=0.
- Mid-window disturbances:
  - ena=0 for 3 cycles after 2 spikes, then ena=1 with 1 spike -> next result rate_out=1.
  - rst mid-window -> no result from that window.

Source files
------------

// File: rtl/lif_rate_decoder_if.sv
// Result bus of the LIF rate decoder: one closed-window result per valid/ready transfer.
interface lif_rate_decoder_if #(
  parameter int unsigned WIN_LOG2 = 8,
  parameter int unsigned ISI_W    = 10
);
  logic                valid;
  logic                ready;
  logic [WIN_LOG2:0]   rate;
  logic [ISI_W-1:0]    isi;
  logic                overrun;

  modport master (output valid, rate, isi, overrun, input ready);
  modport slave  (input valid, rate, isi, overrun, output ready);
endinterface

// File: rtl/lif_rate_decoder.sv
// Spike-train readout: counts spike rising edges per 2^WIN_LOG2-cycle window
// and reports the last inter-spike interval completed inside each window.
module lif_rate_decoder #(
  parameter int unsigned WIN_LOG2 = 8,
  parameter int unsigned ISI_W    = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ena,
  input  logic                 i_spike_in,
  lif_rate_decoder_if.master   o_res
);
  localparam int unsigned CW = WIN_LOG2 + 1;
  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  state_t              r_state;
  logic                r_spike_s;
  logic                r_spike_d;
  logic [WIN_LOG2-1:0] r_wcnt;
  logic [CW-1:0]       r_spike_cnt;
  logic [ISI_W-1:0]    r_isi_timer;
  logic [ISI_W-1:0]    r_win_isi;
  logic                r_have_prev;
  logic                r_valid;
  logic [CW-1:0]       r_rate;
  logic [ISI_W-1:0]    r_isi;
  logic                r_overrun;

  logic                w_edge;
  logic                w_close;
  logic                w_cap;
  logic [ISI_W-1:0]    w_isi_next;

  assign w_edge     = r_spike_s & ~r_spike_d;
  assign w_close    = (r_state == S_COUNT) && i_ena && (r_wcnt == '1);
  assign w_cap      = w_edge & r_have_prev;
  // An interval completing on the closing cycle still belongs to the closing window.
  assign w_isi_next = w_cap ? r_isi_timer : r_win_isi;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_spike_s   <= 1'b0;
      r_spike_d   <= 1'b0;
      r_wcnt      <= '0;
      r_spike_cnt <= '0;
      r_isi_timer <= '0;
      r_win_isi   <= '0;
      r_have_prev <= 1'b0;
      r_valid     <= 1'b0;
      r_rate      <= '0;
      r_isi       <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_spike_s <= i_spike_in;
      r_spike_d <= r_spike_s;

      if (r_valid && o_res.ready) begin
        r_valid <= 1'b0;
      end

      if (r_state == S_IDLE) begin
        if (i_ena) begin
          r_state <= S_COUNT;
        end
      end else if (!i_ena) begin
        // Leaving COUNT drops the partial window and interval history; results stay.
        r_state     <= S_IDLE;
        r_wcnt      <= '0;
        r_spike_cnt <= '0;
        r_isi_timer <= '0;
        r_win_isi   <= '0;
        r_have_prev <= 1'b0;
      end else begin
        r_wcnt <= r_wcnt + WIN_LOG2'(1);

        if (w_edge) begin
          r_isi_timer <= ISI_W'(1);
          r_have_prev <= 1'b1;
        end else if (r_have_prev && (r_isi_timer != ISI_MAX)) begin
          r_isi_timer <= r_isi_timer + ISI_W'(1);
        end

        if (w_close) begin
          r_rate      <= r_spike_cnt + CW'(w_edge);
          r_isi       <= w_isi_next;
          r_valid     <= 1'b1;
          r_spike_cnt <= '0;
          r_win_isi   <= '0;
          if (r_valid && !o_res.ready) begin
            r_overrun <= 1'b1;
          end
        end else begin
          r_spike_cnt <= r_spike_cnt + CW'(w_edge);
          r_win_isi   <= w_isi_next;
        end
      end
    end
  end

  assign o_res.valid   = r_valid;
  assign o_res.rate    = r_rate;
  assign o_res.isi     = r_isi;
  assign o_res.overrun = r_overrun;
endmodule
